// File: rtl/pipe_pkg.sv
// Shared definitions for the accumulator pipeline: opcodes, hazard-control
// FSM states and forwarding-mux select encodings.
package pipe_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDO = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_STO = 3'b011;
  localparam logic [2:0] OP_PRE = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_LDM = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Instructions that read the register named by id_src.
  function automatic logic uses_operand(input logic [2:0] op);
    return (op == OP_STO) || (op == OP_PRE) || (op == OP_ADD) || (op == OP_LDM);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Priority comparator for the EX operand source (EX > MEM > WB) plus the
// load-use hazard flag. Purely combinational.
module fwd_select
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              id_valid,
  input  logic [2:0]        id_opcode,
  input  logic [REG_AW-1:0] id_src,
  input  logic [2:0]        ex_opcode,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              wb_reg_write,
  output logic [1:0]        fwd_sel,
  output logic              hazard
);

  logic uses_op;
  logic ex_match;

  assign uses_op  = id_valid && uses_operand(id_opcode);
  assign ex_match = ex_reg_write && (ex_dest == id_src);
  // A load's data is not ready until MEM, so an EX match on LDA stalls instead.
  assign hazard   = uses_op && ex_match && (ex_opcode == OP_LDA);

  always_comb begin
    fwd_sel = FWD_RF;
    if (uses_op && !hazard) begin
      if (ex_match)                                fwd_sel = FWD_EX;
      else if (mem_reg_write && mem_dest == id_src) fwd_sel = FWD_MEM;
      else if (wb_reg_write && wb_dest == id_src)   fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: load-use stalls, EX operand forwarding select and
// the halt / drain / resume FSM.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [2:0]        id_opcode,
  input  logic [REG_AW-1:0] id_src,
  input  logic [2:0]        ex_opcode,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              wb_reg_write,
  input  logic              resume,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_flush,
  output logic [1:0]        fwd_sel,
  output logic [1:0]        state,
  output logic              halted,
  output logic [7:0]        stall_count
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  hz_state_e  state_q, state_d;
  logic [3:0] drain_q, drain_d;
  logic [7:0] stall_q, stall_d;
  logic [1:0] fwd_raw;
  logic       hazard;
  logic       run_stall;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_select (
    .id_valid      (id_valid),
    .id_opcode     (id_opcode),
    .id_src        (id_src),
    .ex_opcode     (ex_opcode),
    .ex_dest       (ex_dest),
    .ex_reg_write  (ex_reg_write),
    .mem_dest      (mem_dest),
    .mem_reg_write (mem_reg_write),
    .wb_dest       (wb_dest),
    .wb_reg_write  (wb_reg_write),
    .fwd_sel       (fwd_raw),
    .hazard        (hazard)
  );

  // Hazards only matter while instructions are flowing.
  assign run_stall = (state_q == ST_RUN) && hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      drain_q <= 4'd0;
      stall_q <= 8'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    stall_d = stall_q;
    if (run_stall && stall_q != 8'hFF) stall_d = stall_q + 8'd1;
    case (state_q)
      ST_RUN: begin
        if (id_valid && id_opcode == OP_HLT && !hazard) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 4'd0) state_d = ST_HALTED;
        else                 drain_d = drain_q - 4'd1;
      end
      ST_HALTED: begin
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Safe default is "frozen with bubble"; only an active, unstalled RUN opens the pipe.
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_flush = 1'b1;
    fwd_sel     = FWD_RF;
    if (rst && state_q == ST_RUN && !hazard) begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_flush = 1'b0;
      fwd_sel     = fwd_raw;
    end
  end

  assign state       = state_q;
  assign halted      = (state_q == ST_HALTED);
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, load-use stall, forwarding
// priority, halt/drain/resume, stall saturation and reset mid-drain.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_opcode;
  logic [4:0] id_src;
  logic [2:0] ex_opcode;
  logic [4:0] ex_dest;
  logic       ex_reg_write;
  logic [4:0] mem_dest;
  logic       mem_reg_write;
  logic [4:0] wb_dest;
  logic       wb_reg_write;
  logic       resume;
  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_flush;
  logic [1:0] fwd_sel;
  logic [1:0] state;
  logic       halted;
  logic [7:0] stall_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [1:0] exp_q[$];

  pipe_hazard_ctrl #(.REG_AW(5), .DRAIN_CYCLES(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_opcode     (id_opcode),
    .id_src        (id_src),
    .ex_opcode     (ex_opcode),
    .ex_dest       (ex_dest),
    .ex_reg_write  (ex_reg_write),
    .mem_dest      (mem_dest),
    .mem_reg_write (mem_reg_write),
    .wb_dest       (wb_dest),
    .wb_reg_write  (wb_reg_write),
    .resume        (resume),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_ex_flush   (id_ex_flush),
    .fwd_sel       (fwd_sel),
    .state         (state),
    .halted        (halted),
    .stall_count   (stall_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 1'b0; id_opcode = OP_NOP; id_src = 5'd0;
    ex_opcode = OP_NOP; ex_dest = 5'd0; ex_reg_write = 1'b0;
    mem_dest = 5'd0; mem_reg_write = 1'b0;
    wb_dest = 5'd0; wb_reg_write = 1'b0;
  endtask

  task automatic set_id(input logic [2:0] op, input logic [4:0] src);
    id_valid = 1'b1; id_opcode = op; id_src = src;
  endtask

  task automatic set_ex(input logic [2:0] op, input logic [4:0] dst, input logic we);
    ex_opcode = op; ex_dest = dst; ex_reg_write = we;
  endtask

  initial begin
    rst = 1'b1; resume = 1'b0;
    set_idle();
    // A forwardable pattern is present during reset; outputs must stay forced.
    set_id(OP_ADD, 5'd3);
    set_ex(OP_ADD, 5'd3, 1'b1);
    #1 rst = 1'b0;
    #1;
    check_eq("rst_pc_en", pc_en, 0);
    check_eq("rst_if_id_en", if_id_en, 0);
    check_eq("rst_flush", id_ex_flush, 1);
    check_eq("rst_fwd", fwd_sel, FWD_RF);
    check_eq("rst_state", state, ST_RUN);
    check_eq("rst_stall_cnt", stall_count, 0);
    check_eq("rst_halted", halted, 0);
    @(negedge clk);
    set_idle();
    rst = 1'b1;
    tick();
    check_eq("run_pc_en", pc_en, 1);
    check_eq("run_if_id_en", if_id_en, 1);
    check_eq("run_flush", id_ex_flush, 0);

    // Load-use: ADD r3 behind LDA r3
    set_id(OP_ADD, 5'd3);
    set_ex(OP_LDA, 5'd3, 1'b1);
    #1;
    check_eq("lu_pc_en", pc_en, 0);
    check_eq("lu_if_id_en", if_id_en, 0);
    check_eq("lu_flush", id_ex_flush, 1);
    check_eq("lu_fwd", fwd_sel, FWD_RF);
    tick();
    set_ex(OP_NOP, 5'd0, 1'b0);
    mem_dest = 5'd3; mem_reg_write = 1'b1;
    #1;
    check_eq("lu_next_fwd", fwd_sel, FWD_MEM);
    check_eq("lu_next_pc_en", pc_en, 1);
    check_eq("lu_stall_cnt", stall_count, 1);

    // Forwarding priority
    set_idle();
    set_id(OP_PRE, 5'd5);
    set_ex(OP_ADD, 5'd5, 1'b1);
    mem_dest = 5'd5; mem_reg_write = 1'b1;
    wb_dest = 5'd5; wb_reg_write = 1'b1;
    #1;
    check_eq("fwd_ex_prio", fwd_sel, FWD_EX);
    check_eq("fwd_ex_pc_en", pc_en, 1);
    ex_reg_write = 1'b0;
    #1 check_eq("fwd_mem_over_wb", fwd_sel, FWD_MEM);
    mem_reg_write = 1'b0;
    #1 check_eq("fwd_wb", fwd_sel, FWD_WB);
    wb_dest = 5'd6;
    #1 check_eq("fwd_none", fwd_sel, FWD_RF);
    set_id(OP_LDO, 5'd5);
    set_ex(OP_ADD, 5'd5, 1'b1);
    #1 check_eq("fwd_no_operand", fwd_sel, FWD_RF);
    id_valid = 1'b0;
    set_ex(OP_LDA, 5'd5, 1'b1);
    #1;
    check_eq("invalid_fwd", fwd_sel, FWD_RF);
    check_eq("invalid_no_stall", pc_en, 1);
    tick();
    check_eq("invalid_stall_cnt", stall_count, 1);

    // HLT, drain, halt, resume
    set_idle();
    set_id(OP_HLT, 5'd0);
    #1 check_eq("hlt_accept_pc_en", pc_en, 1);
    tick();
    set_idle();
    set_id(OP_ADD, 5'd5);
    set_ex(OP_ADD, 5'd5, 1'b1);
    resume = 1'b1;
    exp_q.push_back(ST_DRAIN);
    exp_q.push_back(ST_DRAIN);
    exp_q.push_back(ST_DRAIN);
    exp_q.push_back(ST_HALTED);
    for (int i = 0; i < 4; i++) begin
      check_eq("hlt_state", state, exp_q.pop_front());
      check_eq("hlt_flush", id_ex_flush, 1);
      check_eq("hlt_pc_en", pc_en, 0);
      if (i < 3) begin
        check_eq("drain_fwd", fwd_sel, FWD_RF);
        check_eq("drain_halted", halted, 0);
      end else begin
        check_eq("halted_flag", halted, 1);
      end
      if (i == 0) resume = 1'b0;
      tick();
    end
    check_eq("halted_hold", state, ST_HALTED);
    set_idle();
    resume = 1'b1;
    #1 check_eq("halted_pc_en", pc_en, 0);
    tick();
    resume = 1'b0;
    check_eq("resume_state", state, ST_RUN);
    check_eq("resume_pc_en", pc_en, 1);
    check_eq("resume_halted", halted, 0);

    // Hazard first, HLT accepted on the following cycle
    set_id(OP_ADD, 5'd3);
    set_ex(OP_LDA, 5'd3, 1'b1);
    #1 check_eq("hlt_hz_pc_en", pc_en, 0);
    tick();
    check_eq("hlt_hz_state", state, ST_RUN);
    check_eq("hlt_hz_stall_cnt", stall_count, 2);
    set_idle();
    set_id(OP_HLT, 5'd0);
    #1 check_eq("hlt_after_hz_pc_en", pc_en, 1);
    tick();
    set_idle();
    check_eq("hlt_after_hz_state", state, ST_DRAIN);
    check_eq("hlt_after_hz_cnt", stall_count, 2);
    repeat (3) tick();
    check_eq("hlt_after_hz_halted", halted, 1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check_eq("resume2_state", state, ST_RUN);

    // Saturation of the stall counter
    set_id(OP_STO, 5'd9);
    set_ex(OP_LDA, 5'd9, 1'b1);
    repeat (300) tick();
    check_eq("sat_stall_cnt", stall_count, 255);
    check_eq("sat_pc_en", pc_en, 0);

    // Reset in the middle of DRAIN
    set_idle();
    set_id(OP_HLT, 5'd0);
    tick();
    check_eq("pre_rst_state", state, ST_DRAIN);
    check_eq("pre_rst_cnt", stall_count, 255);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_state", state, ST_RUN);
    check_eq("mid_rst_cnt", stall_count, 0);
    check_eq("mid_rst_halted", halted, 0);
    check_eq("mid_rst_pc_en", pc_en, 0);
    check_eq("mid_rst_flush", id_ex_flush, 1);
    @(negedge clk);
    set_idle();
    rst = 1'b1;
    tick();
    check_eq("post_rst_state", state, ST_RUN);
    check_eq("post_rst_pc_en", pc_en, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
